instr_encoder: RTL and testbench

- Inverse of the core's immediate extender: packs decoded instruction fields plus a 32-bit signed immediate into a 32-bit RV32 instruction word.
- Immediate-format select uses the same ImmSrc coding as the decode path: 00 I, 01 S, 10 B, 11 R (no immediate).
- Two-stage pipelined block with valid/ready on both sides.
- Used by the self-test instruction generator and the boot loader to build program words; also checks that the immediate is representable in the selected format.

---
 rtl/instr_encoder.sv | 255 +++++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : Packs decoded RV32 instruction fields plus a 32-bit signed
//             immediate into a 32-bit instruction word (the inverse of the
//             core's immediate extender). Flags immediates that cannot be
//             represented in the selected format.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    rst_n      in   1      asynchronous active-low reset
//    in_valid   in   1      input fields valid
//    in_ready   out  1      block can accept this cycle
//    ImmSrc     in   2      format: 00 I, 01 S, 10 B, 11 R (no immediate)
//    opcode     in   7      instr[6:0]
//    rd         in   5      destination register (I/R)
//    rs1        in   5      source register 1
//    rs2        in   5      source register 2 (S/B/R)
//    funct3     in   3      instr[14:12]
//    funct7     in   7      instr[31:25] (R)
//    imm        in   32     signed immediate, byte offset for B
//    out_valid  out  1      encoded word valid
//    out_ready  in   1      consumer accepts
//    instr      out  32     encoded instruction
//    out_err    out  1      immediate not representable (with out_valid)
//    enc_count  out  CNT_W  words accepted at output (wraps)
//    err_count  out  ERR_W  words accepted with out_err=1 (saturates)
// ============================================================================
module instr_encoder #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ImmSrc,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [ERR_W-1:0] err_count
);

    // Immediate-format coding shared with the decode path.
    localparam logic [1:0] c_FMT_I = 2'b00;
    localparam logic [1:0] c_FMT_S = 2'b01;
    localparam logic [1:0] c_FMT_B = 2'b10;
    localparam logic [1:0] c_FMT_R = 2'b11;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] c_ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] c_ERR_MAX = {ERR_W{1'b1}};

    // ------------------------------------------------------------------
    // Stage 1 state: captured fields plus the representability flag.
    // Only imm[12:0] is kept; the upper bits matter only for the range
    // check, which is resolved at capture time.
    // ------------------------------------------------------------------
    logic        s1_valid_q, s1_valid_d;
    logic [1:0]  s1_fmt_q;
    logic [6:0]  s1_opcode_q;
    logic [4:0]  s1_rd_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [2:0]  s1_funct3_q;
    logic [6:0]  s1_funct7_q;
    logic [12:0] s1_imm_q;
    logic        s1_err_q;

    // Stage 2 state: the packed word presented at the output.
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_instr_q;
    logic        s2_err_q;

    // Output-side counters.
    logic [CNT_W-1:0] enc_count_q, enc_count_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic        w_advance;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_fits12;
    logic        w_fits13;
    logic        w_err;
    logic [31:0] w_word;

    // ------------------------------------------------------------------
    // Flow control. Stage 2 can take a new word when it is empty or its
    // word leaves this cycle; stage 1 drains into stage 2 under the same
    // condition, so stage 1 can accept when it is empty or draining.
    // in_ready depends on out_ready and state only, never on in_valid.
    // ------------------------------------------------------------------
    assign w_advance  = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || w_advance;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = s2_valid_q && out_ready;

    // ------------------------------------------------------------------
    // Representability. A value fits an N-bit signed field exactly when
    // every bit above the field's sign bit equals that sign bit.
    //   I/S : 12-bit signed  -> [-2048, 2047]
    //   B   : 13-bit signed and even -> [-4096, 4094]
    // ------------------------------------------------------------------
    assign w_fits12 = (imm[31:11] == {21{1'b0}}) || (imm[31:11] == {21{1'b1}});
    assign w_fits13 = (imm[31:12] == {20{1'b0}}) || (imm[31:12] == {20{1'b1}});

    always_comb begin
        w_err = 1'b0;
        case (ImmSrc)
            c_FMT_I, c_FMT_S: w_err = !w_fits12;
            c_FMT_B:          w_err = !w_fits13 || imm[0];
            default:          w_err = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Word packing from stage-1 fields. On an error the word is still
    // built from the truncated immediate bits so the consumer sees a
    // deterministic value alongside out_err.
    // ------------------------------------------------------------------
    always_comb begin
        w_word        = 32'h0000_0000;
        w_word[6:0]   = s1_opcode_q;
        w_word[14:12] = s1_funct3_q;
        w_word[19:15] = s1_rs1_q;
        case (s1_fmt_q)
            c_FMT_I: begin
                w_word[31:20] = s1_imm_q[11:0];
                w_word[11:7]  = s1_rd_q;
            end
            c_FMT_S: begin
                w_word[31:25] = s1_imm_q[11:5];
                w_word[24:20] = s1_rs2_q;
                w_word[11:7]  = s1_imm_q[4:0];
            end
            c_FMT_B: begin
                // B-type scrambles the offset; bit 0 is implicit (always 0).
                w_word[31]    = s1_imm_q[12];
                w_word[30:25] = s1_imm_q[10:5];
                w_word[24:20] = s1_rs2_q;
                w_word[11:8]  = s1_imm_q[4:1];
                w_word[7]     = s1_imm_q[11];
            end
            default: begin
                w_word[31:25] = s1_funct7_q;
                w_word[24:20] = s1_rs2_q;
                w_word[11:7]  = s1_rd_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state for valid flags and counters.
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s2_valid_d  = s2_valid_q;
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (w_advance) begin
            s2_valid_d = s1_valid_q;
        end
        if (w_out_fire) begin
            enc_count_d = enc_count_q + c_CNT_ONE;
            if (s2_err_q && (err_count_q != c_ERR_MAX)) begin
                err_count_d = err_count_q + c_ERR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= c_FMT_R;
            s1_opcode_q <= 7'h00;
            s1_rd_q     <= 5'h00;
            s1_rs1_q    <= 5'h00;
            s1_rs2_q    <= 5'h00;
            s1_funct3_q <= 3'h0;
            s1_funct7_q <= 7'h00;
            s1_imm_q    <= 13'h0000;
            s1_err_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (w_in_fire) begin
                s1_fmt_q    <= ImmSrc;
                s1_opcode_q <= opcode;
                s1_rd_q     <= rd;
                s1_rs1_q    <= rs1;
                s1_rs2_q    <= rs2;
                s1_funct3_q <= funct3;
                s1_funct7_q <= funct7;
                s1_imm_q    <= imm[12:0];
                s1_err_q    <= w_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers. The word only changes when a real stage-1 word
    // moves in, so instr/out_err stay put while stalled or idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_instr_q <= 32'h0000_0000;
            s2_err_q   <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (w_advance && s1_valid_q) begin
                s2_instr_q <= w_word;
                s2_err_q   <= s1_err_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count_q <= {CNT_W{1'b0}};
            err_count_q <= {ERR_W{1'b0}};
        end else begin
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign instr     = s2_instr_q;
    assign out_err   = s2_err_q;
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Purpose  : Self-checking bench for instr_encoder. Directed encodings,
//             latency, backpressure, async reset, counter saturation/wrap,
//             plus randomized traffic against a field-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int CNT_W = 16;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       ImmSrc = 2'b00;
    logic [6:0]       opcode = 7'h00;
    logic [4:0]       rd = 5'h00;
    logic [4:0]       rs1 = 5'h00;
    logic [4:0]       rs2 = 5'h00;
    logic [2:0]       funct3 = 3'h0;
    logic [6:0]       funct7 = 7'h00;
    logic [31:0]      imm = 32'h0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      instr;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;
    logic [ERR_W-1:0] err_count;

    always #5 clk = ~clk;

    instr_encoder #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ImmSrc(ImmSrc), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    typedef struct packed {
        logic [1:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fields_t;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             pend;
    int               n_total = 0;
    int               n_bad   = 0;
    int               n_xfer  = 0;
    logic             last_acc = 1'b0;
    logic [CNT_W-1:0] m_enc = '0;
    logic [ERR_W-1:0] m_err = '0;

    // ---------------- reference model ----------------
    function automatic longint unsigned bits(longint unsigned u, int hi, int lo);
        return (u >> lo) % (64'd1 << (hi - lo + 1));
    endfunction

    function automatic longint unsigned place(longint unsigned v, int lsb);
        return v * (64'd1 << lsb);
    endfunction

    // Fields occupy disjoint bit ranges, so the word is just their sum.
    function automatic exp_t model(fields_t f);
        exp_t            e;
        longint unsigned u;
        longint unsigned w;
        int              s;
        u = longint'(f.imm);
        s = $signed(f.imm);
        w = place(longint'(f.op), 0) + place(longint'(f.f3), 12) + place(longint'(f.rs1), 15);
        e.err = 1'b0;
        case (f.fmt)
            2'b00: begin
                e.err = (s < -2048) || (s > 2047);
                w = w + place(bits(u, 11, 0), 20) + place(longint'(f.rd), 7);
            end
            2'b01: begin
                e.err = (s < -2048) || (s > 2047);
                w = w + place(bits(u, 11, 5), 25) + place(longint'(f.rs2), 20)
                      + place(bits(u, 4, 0), 7);
            end
            2'b10: begin
                e.err = (s < -4096) || (s > 4094) || ((u % 2) == 1);
                w = w + place(bits(u, 12, 12), 31) + place(bits(u, 10, 5), 25)
                      + place(longint'(f.rs2), 20) + place(bits(u, 4, 1), 8)
                      + place(bits(u, 11, 11), 7);
            end
            default: begin
                w = w + place(longint'(f.f7), 25) + place(longint'(f.rs2), 20)
                      + place(longint'(f.rd), 7);
            end
        endcase
        e.word = w[31:0];
        return e;
    endfunction

    function automatic logic [31:0] pick_imm();
        int bnd[12];
        int r;
        bnd = '{-2048, 2047, -2049, 2048, -4096, 4094, 4095, 4093, -4097, 4096, -4, 0};
        case ($urandom_range(0, 4))
            0:       r = bnd[$urandom_range(0, 11)];
            1:       r = int'($urandom_range(0, 8191)) - 4096;
            2:       r = int'($urandom);
            default: r = int'($urandom_range(0, 63)) - 32;
        endcase
        return 32'(r);
    endfunction

    function automatic fields_t rand_fields(logic [1:0] fmt);
        fields_t     f;
        logic [31:0] r;
        r     = $urandom;
        f.fmt = fmt;
        f.op  = r[6:0];
        f.rd  = r[11:7];
        f.rs1 = r[16:12];
        f.rs2 = r[21:17];
        f.f3  = r[24:22];
        f.f7  = r[31:25];
        f.imm = pick_imm();
        return f;
    endfunction

    function automatic fields_t mk(logic [1:0] fmt, logic [6:0] op, logic [4:0] rd_v,
                                   logic [4:0] rs1_v, logic [4:0] rs2_v, logic [2:0] f3,
                                   logic [6:0] f7, logic [31:0] imm_v);
        fields_t f;
        f.fmt = fmt; f.op = op; f.rd = rd_v; f.rs1 = rs1_v; f.rs2 = rs2_v;
        f.f3 = f3; f.f7 = f7; f.imm = imm_v;
        return f;
    endfunction

    // ---------------- checking / driving helpers ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic present(fields_t f, exp_t e);
        in_valid = 1'b1;
        ImmSrc = f.fmt; opcode = f.op; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2;
        funct3 = f.f3; funct7 = f.f7; imm = f.imm;
        pend = e;
    endtask

    task automatic present_rand(logic [1:0] fmt);
        fields_t f;
        f = rand_fields(fmt);
        present(f, model(f));
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Called at a negedge with inputs already driven; observes the
    // handshakes that will complete at the coming posedge.
    task automatic tick();
        exp_t got;
        #1;
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $error("FAIL spurious_word observed=0x%08h expected=none", instr);
            end else begin
                got = exp_q.pop_front();
                chk("instr", instr, got.word);
                chk("out_err", {31'b0, out_err}, {31'b0, got.err});
                m_enc = m_enc + 1'b1;
                if (got.err && (m_err != '1)) m_err = m_err + 1'b1;
            end
        end
        if (last_acc) exp_q.push_back(pend);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(string tag);
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 16 && exp_q.size() != 0; i++) tick();
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic chk_counters(string tag);
        chk({tag, "_enc"}, {{(32-CNT_W){1'b0}}, enc_count}, {{(32-CNT_W){1'b0}}, m_enc});
        chk({tag, "_err"}, {{(32-ERR_W){1'b0}}, err_count}, {{(32-ERR_W){1'b0}}, m_err});
    endtask

    // Global time bound so a wedged DUT still terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        fields_t     wv[5];
        exp_t        e;
        int          idx;
        int          start;
        int          nwrap;
        logic [31:0] held;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_out_err", {31'b0, out_err}, 0);
        chk("rst_enc", {16'b0, enc_count}, 0);
        chk("rst_err", {24'b0, err_count}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // ADDI x1,x0,5 with latency check
        out_ready = 1'b1;
        e.word = 32'h0050_0093; e.err = 1'b0;
        present(mk(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), e);
        tick();
        idle();
        chk("lat_after_edge1", {31'b0, out_valid}, 0);
        tick();
        chk("lat_after_edge2", {31'b0, out_valid}, 1);
        drain("addi_drain");

        // SW x2,8(x1) then ADD x3,x1,x2 back to back
        e.word = 32'h0020_A423; e.err = 1'b0;
        present(mk(2'b01, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8), e);
        tick();
        e.word = 32'h0020_81B3; e.err = 1'b0;
        present(mk(2'b11, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF), e);
        tick();
        drain("sw_add_drain");

        // BEQ -4, B with odd offset, I with 2048
        e.word = 32'hFE00_0EE3; e.err = 1'b0;
        present(mk(2'b10, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC), e);
        tick();
        e.word = 32'h0000_0163; e.err = 1'b1;
        present(mk(2'b10, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3), e);
        tick();
        e.word = 32'h8000_0093; e.err = 1'b1;
        present(mk(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048), e);
        tick();
        drain("err_drain");
        chk("err_count_two", {24'b0, err_count}, 2);
        chk_counters("directed");

        // Backpressure: 5 words, consumer stalled
        for (int i = 0; i < 5; i++) wv[i] = rand_fields(2'($urandom_range(0, 3)));
        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            present(wv[idx], model(wv[idx]));
            tick();
            if (last_acc) idx++;
        end
        chk("bp_accepts", idx, 2);
        present(wv[idx], model(wv[idx]));
        #1;
        chk("bp_in_ready_low", {31'b0, in_ready}, 0);
        held = instr;
        tick();
        tick();
        chk("bp_instr_held", instr, held);
        chk("bp_still_two", idx, 2);
        out_ready = 1'b1;
        start = n_xfer;
        for (int i = 0; i < 5; i++) begin
            if (idx < 5) present(wv[idx], model(wv[idx]));
            else idle();
            tick();
            if (last_acc) idx++;
        end
        chk("bp_rate", n_xfer - start, 5);
        chk("bp_all_in", idx, 5);
        drain("bp_drain");
        chk_counters("bp");

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) present_rand(2'($urandom_range(0, 3)));
            else idle();
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        drain("rand_drain");
        chk_counters("rand");

        // Asynchronous reset with two words in flight
        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 4 && idx < 2; i++) begin
            present_rand(2'b00);
            tick();
            if (last_acc) idx++;
        end
        idle();
        chk("rst_inflight_two", idx, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 0);
        chk("arst_enc", {16'b0, enc_count}, 0);
        chk("arst_err", {24'b0, err_count}, 0);
        chk("arst_instr", instr, 32'h0);
        exp_q.delete();
        m_enc = '0;
        m_err = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        e.word = 32'h0050_0093; e.err = 1'b0;
        present(mk(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), e);
        tick();
        drain("post_rst_drain");
        chk("post_rst_enc", {16'b0, enc_count}, 1);

        // err_count saturation: odd B offsets always error
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            fields_t f;
            f = rand_fields(2'b10);
            f.imm[0] = 1'b1;
            present(f, model(f));
            tick();
        end
        drain("sat_drain");
        chk("err_saturated", {24'b0, err_count}, 32'h0000_00FF);
        chk_counters("sat");

        // enc_count wrap past all-ones
        nwrap = (1 << CNT_W) - int'(m_enc) + 3;
        for (int i = 0; i < nwrap; i++) begin
            present_rand(2'($urandom_range(0, 3)));
            tick();
        end
        drain("wrap_drain");
        chk("enc_wrapped", {16'b0, enc_count}, 3);
        chk_counters("wrap");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
